// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, per-step
// action encoding and the default PC width.
package pc_seq_pkg;

    localparam int unsigned PcWDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StStep  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ActInc  = 2'd0,
        ActJmp  = 2'd1,
        ActCall = 2'd2,
        ActRet  = 2'd3
    } action_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO used by pc_sequencer.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push, pop    push din / pop top entry (ignored when full / empty)
//   din          value to push
//   dout         current top-of-stack (undefined when empty)
//   full, empty  occupancy flags
//   depth        number of valid entries
module pc_ret_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [DW-1:0]    depth
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    // depth_q doubles as the stack pointer: next free slot, top is one below.
    assign wr_idx = AW'(depth_q);
    assign rd_idx = AW'(depth_q - DW'(1));

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign dout  = mem_q[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[wr_idx] <= din;
            depth_q       <= depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-sequencing controller for pc_counter. Paces fetches against the
// instruction-memory handshake and picks each step's next PC: increment,
// jump, call (push return address) or return (pop).
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start, halt_req     leave IDLE / stop after the current step
//   fetch_ack           memory returned the word at pc
//   jump_req, call_req, ret_req, target   control, sampled on fetch_ack
//   pc                  current PC from pc_counter
//   model_sel           to pc_counter: 1 = load load_value, 0 = increment
//   load_value          to pc_counter
//   fetch_req           request the instruction at pc
//   busy                not in IDLE
//   depth               return-stack occupancy
//   stack_err           sticky overflow/underflow flag
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = PcWDefault,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             halt_req,
    input  logic                             fetch_ack,
    input  logic                             jump_req,
    input  logic                             call_req,
    input  logic                             ret_req,
    input  logic [PC_W-1:0]                  target,
    input  logic [PC_W-1:0]                  pc,
    output logic                             model_sel,
    output logic [PC_W-1:0]                  load_value,
    output logic                             fetch_req,
    output logic                             busy,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_err
);

    state_e           state_q, state_d;
    action_e          action_q, action_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic             err_q, err_set;

    logic             push, pop;
    logic [PC_W-1:0]  stack_dout;
    logic             stack_full, stack_empty;

    pc_ret_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc + PC_W'(1)),
        .dout  (stack_dout),
        .full  (stack_full),
        .empty (stack_empty),
        .depth (depth)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            action_q <= ActInc;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            action_q <= action_d;
            target_q <= target_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        action_d   = action_q;
        target_d   = target_q;
        fetch_req  = 1'b0;
        model_sel  = 1'b1;      // hold: reload the current pc
        load_value = pc;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !halt_req) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    if (ret_req) begin
                        action_d = ActRet;
                    end else if (call_req) begin
                        action_d = ActCall;
                    end else if (jump_req) begin
                        action_d = ActJmp;
                    end else begin
                        action_d = ActInc;
                    end
                    target_d = target;
                    state_d  = StStep;
                end
            end
            StStep: begin
                unique case (action_q)
                    ActInc: begin
                        model_sel = 1'b0;
                    end
                    ActJmp: begin
                        load_value = target_q;
                    end
                    ActCall: begin
                        if (!stack_full) begin
                            push       = 1'b1;
                            load_value = target_q;
                        end else begin
                            // Overflow: drop the call and fall through.
                            model_sel = 1'b0;
                            err_set   = 1'b1;
                        end
                    end
                    ActRet: begin
                        if (!stack_empty) begin
                            pop        = 1'b1;
                            load_value = stack_dout;
                        end else begin
                            model_sel = 1'b0;
                            err_set   = 1'b1;
                        end
                    end
                endcase
                state_d = halt_req ? StIdle : StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign stack_err = err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-sequencing controller that drives the `pc_counter` block's `model_sel`/`load_value` pins. It paces instruction fetch against an instruction-memory handshake and decides each step's next PC: increment, jump, call (push return address), or return (pop). It holds the PC between fetches by reloading the current value. It sits between the decode/control logic and `pc_counter`, with a small internal return-address stack.

## Interface
- `PC_W`, 8, PC width; must match `pc_counter`.
- `STACK_DEPTH`, 4, return-stack entries (≥1).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; shared with `pc_counter`, which resets `pc` to 0.
- `start`  in  1  leave IDLE and begin fetching.
- `halt_req`  in  1  stop after the current step.
- `fetch_ack`  in  1  instruction memory has returned the word at `pc`.
- `jump_req`  in  1  redirect to `target`; sampled on `fetch_ack`.
- `call_req`  in  1  push `pc+1`, redirect to `target`; sampled on `fetch_ack`.
- `ret_req`  in  1  pop the stack into the PC; sampled on `fetch_ack`.
- `target`  in  PC_W  jump/call destination; sampled on `fetch_ack`.
- `pc`  in  PC_W  current value from `pc_counter`.
- `model_sel`  out  1  to `pc_counter`: 1 = load `load_value`, 0 = increment.
- `load_value`  out  PC_W  to `pc_counter`.
- `fetch_req`  out  1  request instruction at `pc`.
- `busy`  out  1  state ≠ IDLE.
- `depth`  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
- `stack_err`  out  1  sticky: overflow or underflow occurred.

## Operation
- **States:** IDLE, FETCH, STEP.
- **Hold rule:** in IDLE and FETCH, `model_sel`=1 and `load_value`=`pc`, so the PC is frozen.
- **IDLE:**
  - `start` & !`halt_req` → FETCH.
  - Otherwise stay (halt wins over start).
- **FETCH:**
  - `fetch_req`=1.
  - On `fetch_ack`, register the action and `target`, then → STEP.
  - Action priority: ret > call > jump > increment.
- **STEP:** `fetch_req`=0; drive the registered action for exactly one cycle:
  - increment: `model_sel`=0.
  - jump: `model_sel`=1, `load_value`=target.
  - call, stack not full: push (pc+1) mod 2^PC_W; load target.
  - call, stack full: no push, no redirect; increment; set `stack_err`.
  - ret, stack not empty: pop; load the popped value.
  - ret, stack empty: increment; set `stack_err`.
  - Exit: `halt_req` high in the STEP cycle → IDLE, else → FETCH.
- **Stack:** LIFO. Push and pop never happen in the same cycle. Contents and `depth` persist across IDLE and are cleared only by reset.
- **`stack_err`:** cleared only by reset.
- **Arithmetic:** return address wraps modulo 2^PC_W (pc=255 → pushes 0 for PC_W=8).

## Timing
- **Reset values (asynchronous, immediate, including mid-fetch):**
  - State IDLE.
  - `fetch_req`=0, `busy`=0, `model_sel`=1, `load_value`=`pc` (=0).
  - `depth`=0, `stack_err`=0, stack pointer 0.
- **Step latency:** minimum 2 cycles per instruction (FETCH with immediate ack, then STEP).
- **PC update:** the new PC is visible one cycle after STEP, at the next FETCH.
- **Handshake:** `fetch_req` stays high until the cycle in which `fetch_ack`=1. `fetch_ack` outside FETCH is ignored.
- **Sampling:** control inputs matter only in the `fetch_ack` cycle. `halt_req` matters only in STEP (and in IDLE, against `start`).
- **Output style:** `model_sel`/`load_value` are combinational from state, registered action and `pc`; they are glitch-free relative to `clk`.
- **Update timing:** `depth` and `stack_err` update at the clock edge ending STEP.

## Structure
- **Shared package `pc_seq_pkg`:**
  - State encoding (IDLE/FETCH/STEP).
  - Action encoding (INC/JMP/CALL/RET).
  - `PC_W` default.
- **Sub-module `pc_ret_stack`:**
  - Parameterized LIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, `depth`.
  - Same clock and asynchronous reset.
- **Top-level contents:** FSM, action register, target register, output mux.

## Test plan
- **Reset then start:** assert reset, release, pulse `start`, ack every FETCH with no control requests → `pc` reads 0,1,2,3 on successive FETCHes; `fetch_req` is low in every STEP.
- **Jump:** at pc=3, ack with `jump_req`=1, `target`=55 → next FETCH has pc=55; then pc=56 after the following step.
- **Call/return:** at pc=10, call `target`=40 → pc=40, `depth`=1. Then ret → pc=11, `depth`=0. Also: call at pc=255 pushes 0.
- **Overflow and underflow:**
  - Five nested calls with STACK_DEPTH=4 → fifth call increments instead of jumping; `stack_err`=1, `depth`=4.
  - After reset, ret with the stack empty → pc increments, `stack_err`=1.
- **Stall and halt:** delay `fetch_ack` 5 cycles → `pc` is unchanged and `fetch_req` stays high. Then assert `halt_req` in STEP → IDLE, `busy`=0, PC held for 10 cycles.
- **Async reset mid-FETCH, and priority:**
  - Reset during FETCH → `fetch_req` and `busy` drop before the next edge; stack cleared.
  - Simultaneous `ret_req`+`call_req`+`jump_req` → ret wins.
